// File: rtl/arbiter_match_ctrl_if.sv
// rtl/arbiter_match_ctrl_if.sv - player-facing signal bundle for the reaction-match controller
interface arbiter_match_ctrl_if;
   logic       tick_in;
   logic       start_in;
   logic       req1_in_n;
   logic       req2_in_n;
   logic [3:0] leds_out;
   logic [2:0] score1_out;
   logic [2:0] score2_out;
   logic       busy_out;
   logic       match_over_out;
   logic [1:0] champ_out;

   modport master (
      output tick_in, start_in, req1_in_n, req2_in_n,
      input  leds_out, score1_out, score2_out, busy_out, match_over_out, champ_out
   );

   modport slave (
      input  tick_in, start_in, req1_in_n, req2_in_n,
      output leds_out, score1_out, score2_out, busy_out, match_over_out, champ_out
   );
endinterface

// File: rtl/arbiter_match_ctrl.sv
// rtl/arbiter_match_ctrl.sv - two-player reaction match: countdown, random dark wait, GO, round display, match end
module arbiter_match_ctrl #(
   parameter int WIN_SCORE  = 3,
   parameter int STEP_TICKS = 4,
   parameter int MIN_WAIT   = 4,
   parameter int SHOW_TICKS = 8
) (
   input logic clk,
   input logic rst_in,
   arbiter_match_ctrl_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_COUNTDOWN, S_WAIT, S_GO, S_SHOW, S_MATCH_END
   } state_t;

   localparam logic [2:0] WIN       = 3'(WIN_SCORE);
   localparam logic [7:0] STEP_LAST = 8'(STEP_TICKS - 1);
   localparam logic [7:0] SHOW_LAST = 8'(SHOW_TICKS - 1);
   localparam logic [7:0] WAIT_BASE = 8'(MIN_WAIT);

   state_t     state;
   logic [1:0] step;
   logic [7:0] tcnt;
   logic [7:0] wcnt;
   logic [1:0] winner;
   logic [7:0] lfsr;

   logic r1_meta, r1_sync, r1_prev;
   logic r2_meta, r2_sync, r2_prev;

   // Synchronizers idle at 1 (released) so reset never fabricates a press.
   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         r1_meta <= 1'b1; r1_sync <= 1'b1; r1_prev <= 1'b1;
         r2_meta <= 1'b1; r2_sync <= 1'b1; r2_prev <= 1'b1;
      end else begin
         r1_meta <= bus.req1_in_n; r1_sync <= r1_meta; r1_prev <= r1_sync;
         r2_meta <= bus.req2_in_n; r2_sync <= r2_meta; r2_prev <= r2_sync;
      end
   end

   logic press1, press2, press_any, enter_show;
   logic [1:0] new_winner;

   always_comb begin
      press1     = r1_prev & ~r1_sync;
      press2     = r2_prev & ~r2_sync;
      press_any  = press1 | press2;
      enter_show = press_any &&
                   (state == S_COUNTDOWN || state == S_WAIT || state == S_GO);
      // Winner code: 01 player 1, 10 player 2, 00 tie; a false start hands the round to the opponent.
      if (press1 && press2)
         new_winner = 2'b00;
      else if (state == S_GO)
         new_winner = press1 ? 2'b01 : 2'b10;
      else
         new_winner = press1 ? 2'b10 : 2'b01;
   end

   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in)
         lfsr <= 8'h01;
      else
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   function automatic logic [3:0] cd_leds(input logic [1:0] s);
      case (s)
         2'd3:    cd_leds = 4'b1111;
         2'd2:    cd_leds = 4'b0111;
         2'd1:    cd_leds = 4'b0011;
         default: cd_leds = 4'b0001;
      endcase
   endfunction

   function automatic logic [3:0] show_start(input logic [1:0] w);
      case (w)
         2'b01:   show_start = 4'b0001;
         2'b10:   show_start = 4'b1000;
         default: show_start = 4'b1001;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         state               <= S_IDLE;
         step                <= 2'd0;
         tcnt                <= 8'd0;
         wcnt                <= 8'd0;
         winner              <= 2'b00;
         bus.leds_out        <= 4'b0000;
         bus.score1_out      <= 3'd0;
         bus.score2_out      <= 3'd0;
         bus.busy_out        <= 1'b0;
         bus.match_over_out  <= 1'b0;
         bus.champ_out       <= 2'b00;
      end else if (enter_show) begin
         state        <= S_SHOW;
         tcnt         <= 8'd0;
         winner       <= new_winner;
         bus.leds_out <= show_start(new_winner);
         if (new_winner == 2'b01 && bus.score1_out < WIN)
            bus.score1_out <= bus.score1_out + 3'd1;
         if (new_winner == 2'b10 && bus.score2_out < WIN)
            bus.score2_out <= bus.score2_out + 3'd1;
      end else begin
         case (state)
            S_IDLE, S_MATCH_END: begin
               if (bus.start_in) begin
                  state              <= S_COUNTDOWN;
                  step               <= 2'd3;
                  tcnt               <= 8'd0;
                  bus.leds_out       <= 4'b1111;
                  bus.score1_out     <= 3'd0;
                  bus.score2_out     <= 3'd0;
                  bus.champ_out      <= 2'b00;
                  bus.busy_out       <= 1'b1;
                  bus.match_over_out <= 1'b0;
               end
            end
            S_COUNTDOWN: begin
               if (bus.tick_in) begin
                  if (tcnt == STEP_LAST) begin
                     tcnt <= 8'd0;
                     if (step == 2'd0) begin
                        state        <= S_WAIT;
                        wcnt         <= WAIT_BASE + {5'd0, lfsr[2:0]};
                        bus.leds_out <= 4'b0000;
                     end else begin
                        step         <= step - 2'd1;
                        bus.leds_out <= cd_leds(step - 2'd1);
                     end
                  end else begin
                     tcnt <= tcnt + 8'd1;
                  end
               end
            end
            S_WAIT: begin
               if (bus.tick_in) begin
                  if (wcnt <= 8'd1) begin
                     state        <= S_GO;
                     bus.leds_out <= 4'b1111;
                  end else begin
                     wcnt <= wcnt - 8'd1;
                  end
               end
            end
            S_GO: begin
               // Held at GO until a press; enter_show handles the exit.
            end
            S_SHOW: begin
               if (bus.tick_in) begin
                  if (tcnt == SHOW_LAST) begin
                     tcnt <= 8'd0;
                     if (bus.score1_out == WIN || bus.score2_out == WIN) begin
                        state              <= S_MATCH_END;
                        bus.leds_out       <= (bus.score1_out == WIN) ? 4'b1100 : 4'b0011;
                        bus.champ_out      <= (bus.score1_out == WIN) ? 2'b01 : 2'b10;
                        bus.busy_out       <= 1'b0;
                        bus.match_over_out <= 1'b1;
                     end else begin
                        state        <= S_COUNTDOWN;
                        step         <= 2'd3;
                        bus.leds_out <= 4'b1111;
                     end
                  end else begin
                     tcnt <= tcnt + 8'd1;
                     if (winner == 2'b01)
                        bus.leds_out <= {bus.leds_out[2:0], bus.leds_out[3]};
                     else if (winner == 2'b10)
                        bus.leds_out <= {bus.leds_out[0], bus.leds_out[3:1]};
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: doc/arbiter_match_ctrl.md
ARBITER_MATCH_CTRL -- requirements
Module: arbiter_match_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 3: round wins needed to take the match (legal 1..7).
REQ-002 Parameter STEP_TICKS, default 4: ticks per countdown step.
REQ-003 Parameter MIN_WAIT, default 4: minimum ticks of the dark wait before GO.
REQ-004 Parameter SHOW_TICKS, default 8: ticks of the round-winner display.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_in  input  1  reset, asynchronous, active-high.
REQ-007 tick_in  input  1  one-cycle prescaler strobe; all display timing counts tick_in cycles.
REQ-008 start_in  input  1  one-cycle request to begin a match.
REQ-009 req1_in_n  input  1  player 1 button, active-low, asynchronous to clk.
REQ-010 req2_in_n  input  1  player 2 button, active-low, asynchronous to clk.
REQ-011 leds_out  output  4  display pattern, registered.
REQ-012 score1_out, score2_out  output  3 each  round wins per player, registered.
REQ-013 busy_out  output  1  high in COUNTDOWN, WAIT, GO, SHOW.
REQ-014 match_over_out  output  1  high in MATCH_END only.
REQ-015 champ_out  output  2  01 player 1, 10 player 2, 00 none; valid while match_over_out high.

Function
REQ-016 Each req input SHALL pass a 2-flop synchronizer; a press event SHALL be a 1->0 transition of the synchronized signal, one cycle wide; held buttons produce no further events.
REQ-017 An 8-bit LFSR (x^8+x^6+x^5+x^4+1) SHALL advance every clk cycle, never reaching 00.
REQ-018 States: IDLE, COUNTDOWN, WAIT, GO, SHOW, MATCH_END.
REQ-019 IDLE: leds 0000; start_in -> COUNTDOWN with both scores cleared to 0.
REQ-020 COUNTDOWN: steps 4,3,2,1 showing 1111, 0111, 0011, 0001; each step lasts STEP_TICKS tick_in pulses counted after entry; after step 1 -> WAIT.
REQ-021 WAIT entry SHALL load wait count = MIN_WAIT + LFSR[2:0] (range MIN_WAIT..MIN_WAIT+7); leds 0000; count reaches zero on tick_in -> GO.
REQ-022 Press event in COUNTDOWN or WAIT = false start: opponent gets one point, -> SHOW with winner = opponent.
REQ-023 Both players false-starting in the same cycle SHALL be a tie: no point, -> SHOW tie.
REQ-024 GO: leds 1111 held until a press event; first event's player gets one point, -> SHOW; both events same cycle = tie, no point; no timeout.
REQ-025 Press events in IDLE, SHOW, MATCH_END SHALL be ignored.
REQ-026 SHOW p1 win: leds start 0001, rotate left one position per tick_in (0001->0010->0100->1000->0001).
REQ-027 SHOW p2 win: leds start 1000, rotate right one position per tick_in.
REQ-028 SHOW tie: leds 1001 static.
REQ-029 SHOW lasts SHOW_TICKS ticks; then if either score == WIN_SCORE -> MATCH_END, else -> COUNTDOWN step 4.
REQ-030 Score update SHALL occur on the cycle of SHOW entry; scores never exceed WIN_SCORE.
REQ-031 MATCH_END: leds 1100 (p1 champion) or 0011 (p2); champ_out set; start_in -> COUNTDOWN with scores cleared, champ_out 00.
REQ-032 start_in outside IDLE/MATCH_END SHALL be ignored.
REQ-033 Latency: button edge to state change = 3 clk cycles (2 sync + 1 edge register) plus one cycle for registered outputs.
REQ-034 tick_in coincident with a state entry SHALL NOT count toward the new state's timing.

Reset
REQ-035 rst_in high SHALL immediately force: IDLE, leds 0000, scores 0, busy 0, match_over 0, champ 00, sync flops 1 (released), edge detectors cleared, LFSR 8'h01, all counters 0.
REQ-036 rst_in asserted mid-match SHALL abandon the match; deassertion returns to IDLE awaiting start_in.

Verification (tick every 4 clk, defaults)
REQ-037 Reset, start_in pulse -> leds 1111, 0111, 0011, 0001 each for 4 ticks, then 0000 for 4..11 ticks, then 1111.
REQ-038 At GO press req1 only -> score1 1, leds 0001,0010,0100,1000,0001... for 8 ticks, then countdown restarts at 1111.
REQ-039 Press req2 during WAIT -> false start, score1 increments, leds rotate left from 0001; score2 unchanged.
REQ-040 Both buttons low in same cycle at GO -> leds 1001 for 8 ticks, scores unchanged.
REQ-041 Player 2 wins 3 GO rounds -> leds 0011, match_over 1, champ 10; start_in -> scores 0, champ 00, countdown.
REQ-042 rst_in pulse during SHOW -> all outputs at reset values same cycle; held buttons after release produce no events until re-pressed.
